// File: rtl/axis_src_pkg.sv
// Shared types and default sizes for the AXI-Stream frame source.
package axis_src_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 2048;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SEND,
    DONE
  } state_t;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/axis_src_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port with enable.
module axis_src_ram
  import axis_src_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int depth      = DEPTH_DEF,
  parameter int aw         = calc_aw(depth)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [aw-1:0]         wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [aw-1:0]         rd_addr,
  output logic [data_width-1:0] rd_data
);

  // Contents are deliberately not reset so a loaded buffer survives a reset.
  logic [data_width-1:0] mem [depth];
  logic [data_width-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_frame_source.sv
// Streams num_words buffered samples over AXI-Stream, tlast every frame_len beats and on the final beat.
// state | meaning
// IDLE  | waiting for start; buffer writable
// PRIME | read of address 0 in flight
// SEND  | streaming; RAM output holds beat k+1 while the output register holds beat k
// DONE  | one-cycle done pulse, then back to IDLE
module axis_frame_source
  import axis_src_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int depth      = DEPTH_DEF,
  parameter int aw         = calc_aw(depth)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [aw-1:0]         wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  start,
  input  logic [aw:0]           num_words,
  input  logic [aw:0]           frame_len,
  output logic [data_width-1:0] data_out,
  output logic                  tvalid_out,
  output logic                  tlast_out,
  input  logic                  tready_in,
  output logic                  busy,
  output logic                  done
);

  localparam logic [aw:0] ONE     = (aw+1)'(1);
  localparam logic [aw:0] DEPTH_W = (aw+1)'(depth);

  state_t                state_q, state_d;
  logic [aw:0]           nw_q, nw_d;
  logic [aw:0]           fl_q, fl_d;
  logic [aw:0]           rd_cnt_q, rd_cnt_d;
  logic [aw:0]           wd_cnt_q, wd_cnt_d;
  logic [aw:0]           fr_cnt_q, fr_cnt_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic                  rd_en;
  logic                  load;
  logic [aw:0]           wd_nxt;
  logic [aw:0]           fr_nxt;
  logic [data_width-1:0] ram_rd_data;
  logic                  ram_wr_en;

  assign busy      = (state_q == PRIME) || (state_q == SEND);
  assign done      = (state_q == DONE);
  assign ram_wr_en = wr_en && !busy;

  axis_src_ram #(
    .data_width(data_width),
    .depth     (depth),
    .aw        (aw)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_cnt_q[aw-1:0]),
    .rd_data(ram_rd_data)
  );

  always_comb begin
    state_d  = state_q;
    nw_d     = nw_q;
    fl_d     = fl_q;
    rd_cnt_d = rd_cnt_q;
    wd_cnt_d = wd_cnt_q;
    fr_cnt_d = fr_cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    rd_en    = 1'b0;
    load     = 1'b0;
    wd_nxt   = wd_cnt_q;
    fr_nxt   = fr_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          nw_d     = (num_words > DEPTH_W) ? DEPTH_W : num_words;
          fl_d     = frame_len;
          rd_cnt_d = '0;
          wd_cnt_d = '0;
          fr_cnt_d = '0;
          state_d  = (num_words == '0) ? DONE : PRIME;
        end
      end
      PRIME: begin
        rd_en    = 1'b1;
        rd_cnt_d = ONE;
        state_d  = SEND;
      end
      SEND: begin
        if (!valid_q) begin
          load   = 1'b1;
          wd_nxt = '0;
          fr_nxt = '0;
        end else if (tready_in) begin
          if (wd_cnt_q == nw_q - ONE) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            state_d = DONE;
          end else begin
            load   = 1'b1;
            wd_nxt = wd_cnt_q + ONE;
            fr_nxt = last_q ? '0 : fr_cnt_q + ONE;
          end
        end
        if (load) begin
          data_d   = ram_rd_data;
          valid_d  = 1'b1;
          wd_cnt_d = wd_nxt;
          fr_cnt_d = fr_nxt;
          last_d   = ((fl_q != '0) && (fr_nxt == fl_q - ONE)) || (wd_nxt == nw_q - ONE);
          // Prefetch the following beat, never past the end of the transfer.
          if (rd_cnt_q < nw_q) begin
            rd_en    = 1'b1;
            rd_cnt_d = rd_cnt_q + ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      nw_q     <= '0;
      fl_q     <= '0;
      rd_cnt_q <= '0;
      wd_cnt_q <= '0;
      fr_cnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nw_q     <= nw_d;
      fl_q     <= fl_d;
      rd_cnt_q <= rd_cnt_d;
      wd_cnt_q <= wd_cnt_d;
      fr_cnt_q <= fr_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign data_out   = data_q;
  assign tvalid_out = valid_q;
  assign tlast_out  = last_q;

endmodule
